// File: rtl/route_sequencer.sv
// Command-driven BRAM transfer sequencer: accepts route descriptors, drives the
// data_route control word and issues the per-beat address/enable/write-enable sequence.
module route_sequencer #(
    parameter int AWIDTH    = 14,
    parameter int CWIDTH    = 15,
    parameter int DRAIN_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         soft_clr,
    input  logic [CWIDTH+2*AWIDTH:0]     s_cmd_tdata,
    input  logic                         s_cmd_tvalid,
    output logic                         s_cmd_tready,
    input  logic                         beat_ready,
    output logic [CWIDTH-1:0]            ctrl,
    output logic [AWIDTH-1:0]            addr,
    output logic                         en,
    output logic                         we,
    output logic                         busy,
    output logic                         done
);

    localparam int DWIDTH = CWIDTH + 2 * AWIDTH + 1;
    localparam bit NO_DRAIN = (DRAIN_CYC == 0);
    localparam logic [4:0] DRAIN_LEN = 5'(DRAIN_CYC);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                we_lat;
    logic [CWIDTH-1:0]   ctrl_lat;
    logic [AWIDTH-1:0]   len_lat;
    logic [AWIDTH-1:0]   addr_reg;
    logic [AWIDTH-1:0]   count;
    logic [3:0]          drain_cnt;
    logic                ready_reg;

    logic                accept;
    logic                last_beat;
    logic                drain_last;

    logic                cmd_we;
    logic [CWIDTH-1:0]   cmd_ctrl;
    logic [AWIDTH-1:0]   cmd_base;
    logic [AWIDTH-1:0]   cmd_len;

    assign cmd_we   = s_cmd_tdata[DWIDTH-1];
    assign cmd_ctrl = s_cmd_tdata[2*AWIDTH+CWIDTH-1:2*AWIDTH];
    assign cmd_base = s_cmd_tdata[2*AWIDTH-1:AWIDTH];
    assign cmd_len  = s_cmd_tdata[AWIDTH-1:0];

    assign accept     = (state == IDLE) && ready_reg && s_cmd_tvalid;
    assign last_beat  = en && (count == len_lat - AWIDTH'(1));
    assign drain_last = (({1'b0, drain_cnt} + 5'd1) == DRAIN_LEN);

    // Next-state logic; soft_clr overrides every transition, including an accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                if (len_lat == '0) state_next = NO_DRAIN ? DONE : DRAIN;
                else               state_next = RUN;
            end
            RUN: begin
                if (last_beat) state_next = NO_DRAIN ? DONE : DRAIN;
            end
            DRAIN: begin
                if (drain_last) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (soft_clr) state_next = IDLE;
    end

    always_comb begin
        en   = (state == RUN) && beat_ready;
        we   = we_lat && en;
        busy = (state != IDLE);
        done = (state == DONE);
        ctrl = '0;
        if (state == SETUP || state == RUN || state == DRAIN) ctrl = ctrl_lat;
    end

    assign addr         = addr_reg;
    assign s_cmd_tready = ready_reg;

    // tready is its own flop so it stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_reg <= 1'b0;
            we_lat    <= 1'b0;
            ctrl_lat  <= '0;
            len_lat   <= '0;
            addr_reg  <= '0;
            count     <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            ready_reg <= (state_next == IDLE);
            if (state != DRAIN) drain_cnt <= '0;
            else                drain_cnt <= drain_cnt + 4'd1;
            if (soft_clr) begin
                ctrl_lat <= '0;
                addr_reg <= '0;
                count    <= '0;
            end else if (accept) begin
                we_lat   <= cmd_we;
                ctrl_lat <= cmd_ctrl;
                len_lat  <= cmd_len;
                addr_reg <= cmd_base;
                count    <= '0;
            end else if (en) begin
                addr_reg <= addr_reg + AWIDTH'(1);
                count    <= count + AWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// Scoreboard bench for route_sequencer: directed descriptors push expected beats and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_route_sequencer;

    localparam int AW = 14;
    localparam int CW = 15;
    localparam int DC = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           soft_clr;
    logic [43:0]    s_cmd_tdata;
    logic           s_cmd_tvalid;
    logic           s_cmd_tready;
    logic           beat_ready;
    logic [CW-1:0]  ctrl;
    logic [AW-1:0]  addr;
    logic           en;
    logic           we;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    route_sequencer #(.AWIDTH(AW), .CWIDTH(CW), .DRAIN_CYC(DC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .soft_clr(soft_clr),
        .s_cmd_tdata(s_cmd_tdata),
        .s_cmd_tvalid(s_cmd_tvalid),
        .s_cmd_tready(s_cmd_tready),
        .beat_ready(beat_ready),
        .ctrl(ctrl),
        .addr(addr),
        .en(en),
        .we(we),
        .busy(busy),
        .done(done)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic          w;
        logic [CW-1:0] c;
    } beat_t;

    beat_t beat_q[$];
    int    done_q[$];
    beat_t mon_exp;
    int    checks = 0;
    int    errors = 0;
    int    cycle = 0;
    int    last_done_cycle = -1;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every en beat and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (en) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat actual addr=0x%0h required none", addr);
                end else begin
                    mon_exp = beat_q.pop_front();
                    checkOutput("beat", {2'b0, addr, we, ctrl}, {2'b0, mon_exp});
                end
            end
            if (done) begin
                last_done_cycle = cycle;
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done actual=1 required=0 cycle=%0d", cycle);
                end else begin
                    void'(done_q.pop_front());
                    checkOutput("done_tready", {31'b0, s_cmd_tready}, 32'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic [CW-1:0] c, input logic [AW-1:0] b,
                                 input logic [AW-1:0] l, input int nexp, input bit expdone,
                                 input bit hold, output int acc);
        int n;
        beat_t e;
        n = 0;
        s_cmd_tdata  = {w, c, b, l};
        s_cmd_tvalid = 1'b1;
        while (!s_cmd_tready && n < 200) begin
            step();
            n++;
        end
        if (!s_cmd_tready) checkOutput("accept_timeout", 32'd0, 32'd1);
        acc = cycle;
        for (int i = 0; i < nexp; i++) begin
            e.a = b + AW'(i);
            e.w = w;
            e.c = c;
            beat_q.push_back(e);
        end
        if (expdone) done_q.push_back(acc);
        step();
        if (!hold) s_cmd_tvalid = 1'b0;
    endtask

    task automatic waitDone(output int dc);
        int n;
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        checkOutput("done_seen", {31'b0, done}, 32'd1);
        checkOutput("done_ctrl", {17'b0, ctrl}, 32'd0);
        dc = cycle;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, {17'b0, ctrl}, 32'd0);
        checkOutput({tag, "_addr"}, {18'b0, addr}, 32'd0);
        checkOutput({tag, "_en"}, {31'b0, en}, 32'd0);
        checkOutput({tag, "_we"}, {31'b0, we}, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acc;
        int acc2;
        int dc;

        rst_n        = 1'b0;
        soft_clr     = 1'b0;
        s_cmd_tdata  = '0;
        s_cmd_tvalid = 1'b0;
        beat_ready   = 1'b1;
        #1;
        checkIdleOutputs("reset");
        checkOutput("reset_tready", {31'b0, s_cmd_tready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        checkOutput("release_tready", {31'b0, s_cmd_tready}, 32'd1);

        // Basic transfer
        applyStimulus(1'b1, 15'h0049, 14'h0100, 14'd4, 4, 1'b1, 1'b0, acc);
        checkOutput("basic_setup_busy", {31'b0, busy}, 32'd1);
        checkOutput("basic_setup_ctrl", {17'b0, ctrl}, 32'h49);
        checkOutput("basic_setup_en", {31'b0, en}, 32'd0);
        checkOutput("basic_setup_addr", {18'b0, addr}, 32'h100);
        waitDone(dc);
        checkOutput("basic_done_time", dc - acc, 32'd8);
        step();
        checkOutput("basic_idle_tready", {31'b0, s_cmd_tready}, 32'd1);
        checkOutput("basic_idle_busy", {31'b0, busy}, 32'd0);

        // Wrap and stall
        applyStimulus(1'b0, 15'h7FFF, 14'h3FFE, 14'd4, 4, 1'b1, 1'b0, acc);
        step();
        step();
        beat_ready = 1'b0;
        #1;
        checkOutput("stall_en", {31'b0, en}, 32'd0);
        checkOutput("stall_addr", {18'b0, addr}, 32'h3FFF);
        step();
        beat_ready = 1'b1;
        waitDone(dc);
        checkOutput("wrap_done_time", dc - acc, 32'd9);

        // Zero length
        applyStimulus(1'b1, 15'h0155, 14'h0AAA, 14'd0, 0, 1'b1, 1'b0, acc);
        checkOutput("zero_setup_ctrl", {17'b0, ctrl}, 32'h155);
        step();
        checkOutput("zero_drain1_ctrl", {17'b0, ctrl}, 32'h155);
        checkOutput("zero_drain1_en", {31'b0, en}, 32'd0);
        step();
        checkOutput("zero_drain2_ctrl", {17'b0, ctrl}, 32'h155);
        waitDone(dc);
        checkOutput("zero_done_time", dc - acc, 32'd4);

        // Back-to-back with tvalid held
        applyStimulus(1'b1, 15'h0011, 14'h0010, 14'd3, 3, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 15'h0022, 14'h0020, 14'd2, 2, 1'b1, 1'b0, acc2);
        checkOutput("b2b_accept_after_done", acc2, last_done_cycle + 1);
        checkOutput("b2b_spacing", acc2 - acc, 32'd8);
        checkOutput("b2b_second_ctrl", {17'b0, ctrl}, 32'h22);
        waitDone(dc);
        checkOutput("b2b_second_done_time", dc - acc2, 32'd6);
        step();

        // soft_clr coinciding with an accept: handshake completes, descriptor discarded
        s_cmd_tdata  = {1'b1, 15'h0077, 14'h0123, 14'd5};
        s_cmd_tvalid = 1'b1;
        soft_clr     = 1'b1;
        checkOutput("clr_accept_tready", {31'b0, s_cmd_tready}, 32'd1);
        step();
        s_cmd_tvalid = 1'b0;
        soft_clr     = 1'b0;
        checkOutput("clr_accept_busy", {31'b0, busy}, 32'd0);
        checkOutput("clr_accept_addr", {18'b0, addr}, 32'd0);
        step();

        // Abort during beat 3 of len=10
        applyStimulus(1'b1, 15'h1234, 14'h0200, 14'd10, 3, 1'b0, 1'b0, acc);
        step();
        step();
        step();
        soft_clr = 1'b1;
        step();
        soft_clr = 1'b0;
        checkIdleOutputs("abort");
        checkOutput("abort_tready", {31'b0, s_cmd_tready}, 32'd1);
        repeat (3) step();
        applyStimulus(1'b1, 15'h0300, 14'h0050, 14'd3, 3, 1'b1, 1'b0, acc);
        waitDone(dc);
        checkOutput("post_abort_done_time", dc - acc, 32'd7);
        step();

        // Asynchronous reset mid-RUN, between clock edges
        applyStimulus(1'b0, 15'h0044, 14'h1000, 14'd6, 2, 1'b0, 1'b0, acc);
        step();
        step();
        #6;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("async_reset");
        checkOutput("async_reset_tready", {31'b0, s_cmd_tready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        checkOutput("rerelease_tready", {31'b0, s_cmd_tready}, 32'd1);
        applyStimulus(1'b1, 15'h0000, 14'h0007, 14'd5, 5, 1'b1, 1'b0, acc);
        waitDone(dc);
        checkOutput("post_reset_done_time", dc - acc, 32'd9);

        step();
        step();
        checkOutput("beat_q_empty", beat_q.size(), 32'd0);
        checkOutput("done_q_empty", done_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
